// File: rtl/fp16_pkg.sv
// Shared fp16 constants, FSM state type and operand classification helper.
package fp16_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int signed   BIAS   = 15;

    localparam logic [15:0]      FP16_QNAN    = 16'h7E00;
    localparam logic [15:0]      FP16_INF     = 16'h7C00;
    localparam logic [EXP_W-1:0] FP16_EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} mul_state_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp16_cls_t;

    // Subnormals have exp==0 and are treated as zero (flush-to-zero).
    function automatic fp16_cls_t fp16_classify(input logic [15:0] x);
        fp16_cls_t c;
        c.zero = (x[14:10] == '0);
        c.inf  = (x[14:10] == FP16_EXP_MAX) && (x[9:0] == '0);
        c.nan  = (x[14:10] == FP16_EXP_MAX) && (x[9:0] != '0);
        return c;
    endfunction

endpackage

// File: rtl/float_mul16_seq_if.sv
// Operand/result valid-ready bus of the sequential fp16 multiplier.
interface float_mul16_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] numA;
    logic [15:0] numB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;

    modport master (
        output in_valid, numA, numB, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, numA, numB, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/fp16_norm_round.sv
// Normalizes a 22-bit mantissa product, rounds to nearest-even and packs an fp16 result,
// clamping overflow to signed inf and underflow to signed zero.
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic [PROD_W-1:0] prod_i,
    input  logic signed [6:0] exp_i,
    input  logic              sign_i,
    output logic [15:0]       res_o
);

    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [FRAC_W:0]   frac_rnd;
    logic signed [7:0] exp_n;
    logic signed [7:0] exp_r;

    // Normalize by at most one position, then round and clamp the exponent range.
    always_comb begin
        if (prod_i[PROD_W-1]) begin
            frac   = prod_i[PROD_W-2 -: FRAC_W];
            guard  = prod_i[FRAC_W];
            sticky = |prod_i[FRAC_W-1:0];
            exp_n  = {exp_i[6], exp_i} + 8'sd1;
        end else begin
            frac   = prod_i[PROD_W-3 -: FRAC_W];
            guard  = prod_i[FRAC_W-1];
            sticky = |prod_i[FRAC_W-2:0];
            exp_n  = {exp_i[6], exp_i};
        end
        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
        // Carry out of the fraction means 1.111..1 rounded up to 10.000..0.
        exp_r = frac_rnd[FRAC_W] ? exp_n + 8'sd1 : exp_n;
        if (exp_r >= 8'sd31) begin
            res_o = {sign_i, FP16_INF[14:0]};
        end else if (exp_r <= 8'sd0) begin
            res_o = {sign_i, 15'h0000};
        end else begin
            res_o = {sign_i, exp_r[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/float_mul16_seq.sv
// Sequential fp16 multiplier: 11-cycle shift-add mantissa core, one normalize/round cycle,
// fixed latency for every operand class, valid/ready on both sides.
module float_mul16_seq
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    float_mul16_seq_if.slave  bus
);

    mul_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;
    logic              zero_q, zero_d;
    logic signed [6:0] exp_q, exp_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [MANT_W-1:0] mplier_q, mplier_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_q, out_d;
    logic [15:0]       norm_res;
    fp16_cls_t         cls_a, cls_b;

    assign cls_a = fp16_classify(bus.numA);
    assign cls_b = fp16_classify(bus.numB);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

    fp16_norm_round u_norm_round (
        .prod_i (prod_q),
        .exp_i  (exp_q),
        .sign_i (sign_q),
        .res_o  (norm_res)
    );

    // Next-state logic for the IDLE -> MUL -> NORM -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        exp_d       = exp_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        mplier_d    = mplier_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d     = bus.numA[15] ^ bus.numB[15];
                    nan_d      = cls_a.nan | cls_b.nan | (cls_a.inf & cls_b.zero) |
                                 (cls_b.inf & cls_a.zero);
                    inf_d      = cls_a.inf | cls_b.inf;
                    zero_d     = cls_a.zero | cls_b.zero;
                    exp_d      = {2'b00, bus.numA[14:10]} + {2'b00, bus.numB[14:10]} - 7'(BIAS);
                    // Hidden bit is dropped for zero/subnormal operands.
                    mcand_d    = {{MANT_W{1'b0}}, ~cls_a.zero, bus.numA[FRAC_W-1:0]};
                    mplier_d   = {~cls_b.zero, bus.numB[FRAC_W-1:0]};
                    prod_d     = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = StMul;
                end
            end
            StMul: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'(MANT_W - 1)) begin
                    cnt_d   = '0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (nan_q) begin
                    out_d = FP16_QNAN;
                end else if (inf_q) begin
                    out_d = {sign_q, FP16_INF[14:0]};
                end else if (zero_q) begin
                    out_d = {sign_q, 15'h0000};
                end else begin
                    out_d = norm_res;
                end
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            exp_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            mplier_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            exp_q       <= exp_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            mplier_q    <= mplier_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_float_mul16_seq.sv
// Self-checking bench for float_mul16_seq: vector table through a scoreboard, plus reset,
// backpressure and back-to-back sequences.
module tb_float_mul16_seq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        int          acc;
    } sb_t;

    localparam int NVEC = 17;

    logic clk = 1'b0;
    logic rst;

    float_mul16_seq_if bus ();

    float_mul16_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic ov_prev = 1'b0;
    vec_t pend[$];
    sb_t  sb[$];
    int   rises[$];
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        if (pend.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.numA     = pend[0].a;
            bus.numB     = pend[0].b;
        end else begin
            bus.in_valid = 1'b0;
            bus.numA     = 16'h0000;
            bus.numB     = 16'h0000;
        end
    endtask

    // One clock: observe at negedge (scoreboard push/pop), then drive 1 time unit after posedge.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (bus.out_valid && !ov_prev) begin
            rises.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: out_valid=1 out=%h with nothing outstanding", bus.out);
            end else begin
                check("latency", 16'(cyc - sb[0].acc + 1), 16'd13);
            end
        end
        ov_prev = bus.out_valid;
        if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
            check("result", bus.out, sb[0].exp);
            void'(sb.pop_front());
        end
        if (bus.in_valid && bus.in_ready && pend.size() > 0) begin
            e.exp = pend[0].exp;
            e.acc = cyc + 1;
            sb.push_back(e);
            void'(pend.pop_front());
        end
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (pend.size() > 0 || sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: pending=%0d outstanding=%0d after %0d cycles",
                     pend.size(), sb.size(), n);
            pend.delete();
            sb.delete();
            drive();
        end
    endtask

    initial begin
        vec_t v;
        int   n;

        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00};
        vecs[1]  = '{16'h4000, 16'h4200, 16'h4600};
        vecs[2]  = '{16'h3E00, 16'h3E00, 16'h4080};
        vecs[3]  = '{16'hC000, 16'h3800, 16'hBC00};
        vecs[4]  = '{16'h3C01, 16'h3C01, 16'h3C02};
        vecs[5]  = '{16'h7BFF, 16'h7BFF, 16'h7C00};
        vecs[6]  = '{16'h0400, 16'h0400, 16'h0000};
        vecs[7]  = '{16'h7C00, 16'h0000, 16'h7E00};
        vecs[8]  = '{16'h7E00, 16'h3C00, 16'h7E00};
        vecs[9]  = '{16'hFC00, 16'h3C00, 16'hFC00};
        vecs[10] = '{16'h8000, 16'h4000, 16'h8000};
        vecs[11] = '{16'h3C01, 16'h3E00, 16'h3E02};  // tie, odd lsb -> up
        vecs[12] = '{16'h3C03, 16'h3E00, 16'h3E04};  // tie, even lsb -> stays
        vecs[13] = '{16'h3DA8, 16'h3DA8, 16'h4000};  // rounding carry renormalizes
        vecs[14] = '{16'h2000, 16'h2000, 16'h0400};  // smallest normal result
        vecs[15] = '{16'h2000, 16'h1C00, 16'h0000};  // E == 0 -> zero
        vecs[16] = '{16'h0001, 16'hBC00, 16'h8000};  // subnormal flushed, signed zero

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.numA      = 16'h0000;
        bus.numB      = 16'h0000;
        bus.out_ready = 1'b1;
        #2;
        check("reset_in_ready", {15'h0, bus.in_ready}, 16'h0001);
        check("reset_out_valid", {15'h0, bus.out_valid}, 16'h0000);
        check("reset_out", bus.out, 16'h0000);
        repeat (2) @(posedge clk);
        cyc = 2;
        #1;
        rst = 1'b0;

        // Vector table, one operation at a time.
        for (int i = 0; i < NVEC; i++) begin
            pend.push_back(vecs[i]);
            drive();
            run_until_idle(40);
        end

        // Reset pulsed 5 cycles into MUL: operation is dropped, outputs return to reset values.
        v = '{16'h3C00, 16'h3C00, 16'h3C00};
        pend.push_back(v);
        drive();
        n = 0;
        while (sb.size() == 0 && n < 10) begin
            step();
            n++;
        end
        check("rst_accepted", 16'(sb.size()), 16'd1);
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {15'h0, bus.out_valid}, 16'h0000);
        check("rst_mid_in_ready", {15'h0, bus.in_ready}, 16'h0001);
        check("rst_mid_out", bus.out, 16'h0000);
        #2;
        rst = 1'b0;
        sb.delete();
        ov_prev = 1'b0;
        repeat (16) step();
        v = '{16'h4000, 16'h4200, 16'h4600};
        pend.push_back(v);
        drive();
        run_until_idle(40);

        // Backpressure: result held 20 cycles, new operands refused meanwhile.
        bus.out_ready = 1'b0;
        v = '{16'h4000, 16'h4200, 16'h4600};
        pend.push_back(v);
        drive();
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        check("bp_out_valid", {15'h0, bus.out_valid}, 16'h0001);
        v = '{16'h3C00, 16'hC200, 16'hC200};
        pend.push_back(v);
        drive();
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_hold", bus.out, 16'h4600);
            check("bp_in_ready", {15'h0, bus.in_ready}, 16'h0000);
        end
        check("bp_pending_kept", 16'(pend.size()), 16'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_in_ready_after_hs", {15'h0, bus.in_ready}, 16'h0001);
        check("bp_out_valid_dropped", {15'h0, bus.out_valid}, 16'h0000);
        run_until_idle(40);

        // Back-to-back: three operations with in_valid held, results 14 cycles apart.
        rises.delete();
        v = '{16'h4000, 16'h4000, 16'h4400};
        pend.push_back(v);
        v = '{16'h3C00, 16'hC200, 16'hC200};
        pend.push_back(v);
        v = '{16'h3800, 16'h3800, 16'h3400};
        pend.push_back(v);
        drive();
        run_until_idle(80);
        check("b2b_count", 16'(rises.size()), 16'd3);
        if (rises.size() == 3) begin
            check("b2b_spacing_1", 16'(rises[1] - rises[0]), 16'd14);
            check("b2b_spacing_2", 16'(rises[2] - rises[1]), 16'd14);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
